// File: rtl/i2c_pkg.sv
// Shared constants and FSM state encoding for the I2C register target.
package i2c_pkg;

    // 7-bit bus address of the SGTL5000 codec this target stands in for.
    localparam logic [6:0] SGTL5000_ADDR = 7'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_RA_HI,
        ST_RA_LO,
        ST_WR_HI,
        ST_WR_LO,
        ST_RD_HI,
        ST_RD_LO,
        ST_MACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus 3-sample stability filter for one raw I2C line,
// with single-cycle rise/fall pulses of the filtered level.
module i2c_line_filter (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] r_sync;
    logic [2:0] r_hist;
    logic       r_level;
    logic       r_level_d;

    // Two-flop sync, then the level only moves after 3 identical samples; all preset to idle-high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_hist    <= 3'b111;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_line};
            r_hist    <= {r_hist[1:0], r_sync[1]};
            if (&r_hist)
                r_level <= 1'b1;
            else if (~|r_hist)
                r_level <= 1'b0;
            r_level_d <= r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;
    assign o_fall  = ~r_level & r_level_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16-bit register bus: 16-bit register pointer,
// 16-bit data words, optional pointer post-increment by 2 per word.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR     = SGTL5000_ADDR,
    parameter int         AUTO_INC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        busy
);
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    state_t      r_state, r_next;
    logic [3:0]  r_cnt;
    logic [7:0]  r_rx, r_hi;
    logic [15:0] r_tx;
    logic        r_mack, r_inc_pend, r_rd_pend, r_rd_load;
    logic        r_sda_oe, r_we, r_re, r_busy;
    logic [15:0] r_addr, r_wdata;

    i2c_line_filter u_scl (.i_clk(clk), .i_rst(rst), .i_line(scl_i),
                           .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
    i2c_line_filter u_sda (.i_clk(clk), .i_rst(rst), .i_line(sda_i),
                           .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_rx[6:0], w_sda};

    // Protocol FSM; START/STOP override every state, START taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_next     <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_rx       <= 8'd0;
            r_hi       <= 8'd0;
            r_tx       <= 16'd0;
            r_mack     <= 1'b0;
            r_inc_pend <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_load  <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_busy     <= 1'b0;
            r_addr     <= 16'd0;
            r_wdata    <= 16'd0;
        end else begin
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_inc_pend <= 1'b0;
            r_rd_pend  <= 1'b0;
            // Read data is captured the cycle after the reg_re pulse.
            r_rd_load  <= r_re;
            if (r_rd_load)
                r_tx <= reg_rdata;
            if (r_inc_pend)
                r_addr <= r_addr + 16'd2;
            // Next-word read is issued one cycle after the pointer bump so it sees the new address.
            if (r_rd_pend)
                r_re <= 1'b1;

            if (w_start) begin
                r_state  <= ST_ADDR;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_RA_HI, ST_RA_LO, ST_WR_HI, ST_WR_LO: begin
                        if (w_scl_rise && r_cnt < 4'd8) begin
                            r_rx  <= w_byte;
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                case (r_state)
                                    ST_RA_HI, ST_WR_HI: r_hi <= w_byte;
                                    ST_RA_LO:           r_addr <= {r_hi, w_byte};
                                    ST_WR_LO: begin
                                        r_wdata    <= {r_hi, w_byte};
                                        r_we       <= 1'b1;
                                        r_inc_pend <= (AUTO_INC != 0);
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        if (w_scl_fall && r_cnt == 4'd8) begin
                            r_cnt <= 4'd0;
                            if (r_state == ST_ADDR && r_rx[7:1] != ADDR) begin
                                r_state <= ST_IGNORE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state  <= ST_ACK;
                                r_sda_oe <= 1'b1;
                                case (r_state)
                                    ST_ADDR: begin
                                        r_busy <= 1'b1;
                                        if (r_rx[0]) begin
                                            r_next <= ST_RD_HI;
                                            r_re   <= 1'b1;
                                        end else begin
                                            r_next <= ST_RA_HI;
                                        end
                                    end
                                    ST_RA_HI: r_next <= ST_RA_LO;
                                    ST_WR_HI: r_next <= ST_WR_LO;
                                    default:  r_next <= ST_WR_HI;
                                endcase
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= r_next;
                            r_cnt    <= 4'd0;
                            r_sda_oe <= (r_next == ST_RD_HI) ? ~r_tx[15] : 1'b0;
                        end
                    end
                    ST_RD_HI, ST_RD_LO: begin
                        if (w_scl_rise)
                            r_cnt <= r_cnt + 4'd1;
                        if (w_scl_fall) begin
                            r_tx <= {r_tx[14:0], 1'b0};
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_MACK;
                                r_next   <= (r_state == ST_RD_HI) ? ST_RD_LO : ST_RD_HI;
                            end else begin
                                r_sda_oe <= ~r_tx[14];
                            end
                        end
                    end
                    ST_MACK: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda;
                            if (!w_sda && r_next == ST_RD_HI) begin
                                if (AUTO_INC != 0)
                                    r_addr <= r_addr + 16'd2;
                                r_rd_pend <= 1'b1;
                            end
                        end
                        if (w_scl_fall) begin
                            r_cnt <= 4'd0;
                            if (r_mack) begin
                                r_state  <= ST_IGNORE;
                                r_busy   <= 1'b0;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_state  <= r_next;
                                r_sda_oe <= ~r_tx[15];
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench: bit-banged I2C master, open-drain SDA, a register-file model and a
// pointer model derived from the protocol rules.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int H = 16;  // SCL high/low time in clk cycles
    localparam int Q = 8;   // data setup after SCL fall

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl, m_sda;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_we, reg_re, busy;

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        logic [15:0] d;
        d = (a - 16'd2) * 16'h1111;
        return 16'hA55A ^ d;
    endfunction

    assign sda_bus   = m_sda & ~sda_oe;
    assign reg_rdata = rd_word(reg_addr);

    i2c_target_regs dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    // Event monitor (single writer of everything below)
    logic [15:0] we_addr_q[$], we_data_q[$], re_addr_q[$];
    int oe_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    int n_checks = 0, n_errors = 0;
    logic [15:0] model_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic m_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(H);
        m_sda = 1'b0; tick(H);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(H);
        m_sda = 1'b1; tick(H);
    endtask

    task automatic m_send_bit(input logic b);
        m_sda = b; tick(Q);
        m_scl = 1'b1; tick(H);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_recv_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(H / 2);
        @(negedge clk);
        b = sda_bus;
        tick(H / 2);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) m_send_bit(d[i]);
        m_recv_bit(b);
        ack = ~b;
    endtask

    task automatic m_read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_recv_bit(b);
            d[i] = b;
        end
        m_send_bit(~ack);
    endtask

    // Full write transaction: pointer + nw words; expectations from the protocol rules.
    task automatic run_write(input string tag, input logic [6:0] dev, input logic [15:0] ptr,
                             input int nw, input logic [3:0][15:0] data,
                             input logic exp_match, input int exp_acks);
        logic ack;
        int acks, we0, oe0, bz0;
        logic [15:0] ea, ed;
        we0 = we_addr_q.size(); oe0 = oe_cnt; bz0 = busy_cnt; acks = 0;
        m_start();
        m_write_byte({dev, 1'b0}, ack);
        acks += int'(ack);
        chk({tag, " addr_ack"}, 32'(ack), 32'(exp_match));
        if (exp_match) begin
            m_write_byte(ptr[15:8], ack); acks += int'(ack);
            m_write_byte(ptr[7:0], ack);  acks += int'(ack);
            for (int i = 0; i < nw; i++) begin
                ed = data[i];
                m_write_byte(ed[15:8], ack); acks += int'(ack);
                m_write_byte(ed[7:0], ack);  acks += int'(ack);
            end
        end
        m_stop();
        tick(4);
        chk({tag, " ack_count"}, acks, exp_acks);
        chk({tag, " we_count"}, we_addr_q.size() - we0, exp_match ? nw : 0);
        if (exp_match) begin
            for (int i = 0; i < nw; i++) begin
                if (we0 + i < we_addr_q.size()) begin
                    ea = ptr + 16'(2 * i);
                    chk($sformatf("%s we_addr[%0d]", tag, i), we_addr_q[we0 + i], ea);
                    chk($sformatf("%s we_data[%0d]", tag, i), we_data_q[we0 + i], data[i]);
                end
            end
            model_ptr = ptr + 16'(2 * nw);
        end
        chk({tag, " oe_seen"}, 32'(oe_cnt > oe0), 32'(exp_match));
        chk({tag, " busy_seen"}, 32'(busy_cnt > bz0), 32'(exp_match));
        chk({tag, " busy_after"}, 32'(busy), 0);
        chk({tag, " reg_addr"}, reg_addr, model_ptr);
    endtask

    // Pointer write, repeated START, read nw words (ACK all but the final byte).
    task automatic run_read(input string tag, input logic [15:0] ptr, input int nw);
        logic ack, last;
        logic [7:0] d;
        logic [15:0] ew, ea;
        int re0, we0;
        re0 = re_addr_q.size(); we0 = we_addr_q.size();
        m_start();
        m_write_byte(8'h14, ack);     chk({tag, " wr_addr_ack"}, 32'(ack), 1);
        m_write_byte(ptr[15:8], ack); chk({tag, " ptr_hi_ack"}, 32'(ack), 1);
        m_write_byte(ptr[7:0], ack);  chk({tag, " ptr_lo_ack"}, 32'(ack), 1);
        m_start();
        m_write_byte(8'h15, ack);     chk({tag, " rd_addr_ack"}, 32'(ack), 1);
        for (int w = 0; w < nw; w++) begin
            ew = rd_word(ptr + 16'(2 * w));
            for (int h = 0; h < 2; h++) begin
                last = (w == nw - 1) && (h == 1);
                m_read_byte(d, ~last);
                chk($sformatf("%s byte[%0d]", tag, 2 * w + h), d, (h == 0) ? ew[15:8] : ew[7:0]);
            end
        end
        m_stop();
        tick(4);
        chk({tag, " re_count"}, re_addr_q.size() - re0, nw);
        for (int w = 0; w < nw; w++) begin
            if (re0 + w < re_addr_q.size()) begin
                ea = ptr + 16'(2 * w);
                chk($sformatf("%s re_addr[%0d]", tag, w), re_addr_q[re0 + w], ea);
            end
        end
        chk({tag, " no_we"}, we_addr_q.size() - we0, 0);
        model_ptr = ptr + 16'(2 * (nw - 1));
        chk({tag, " reg_addr"}, reg_addr, model_ptr);
        chk({tag, " busy_after"}, 32'(busy), 0);
    endtask

    typedef struct {
        logic [6:0]       dev;
        logic [15:0]      ptr;
        int               nw;
        logic [3:0][15:0] data;
        logic             exp_match;
        int               exp_acks;
    } wvec_t;

    wvec_t vt[4];

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic ack;
        logic [6:0] rdev;
        logic [15:0] rptr;
        logic [3:0][15:0] rdat;
        int rnw, we0, waited;

        vt[0] = '{7'h0A, 16'h0030, 1, {16'h0, 16'h0, 16'h0, 16'h1234}, 1'b1, 5};
        vt[1] = '{7'h0B, 16'h0030, 1, {16'h0, 16'h0, 16'h0, 16'h1234}, 1'b0, 0};
        vt[2] = '{7'h0A, 16'hFFFE, 2, {16'h0, 16'h0, 16'hCAFE, 16'hBEEF}, 1'b1, 7};
        vt[3] = '{7'h0A, 16'h0100, 0, {16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 3};

        m_scl = 1'b1; m_sda = 1'b1; rst = 1'b1;
        model_ptr = 16'h0000;
        tick(5);
        @(negedge clk);
        chk("reset sda_oe", 32'(sda_oe), 0);
        chk("reset reg_we", 32'(reg_we), 0);
        chk("reset reg_re", 32'(reg_re), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset reg_addr", reg_addr, 16'h0000);
        chk("reset reg_wdata", reg_wdata, 16'h0000);
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 4; i++)
            run_write($sformatf("vec%0d", i), vt[i].dev, vt[i].ptr, vt[i].nw, vt[i].data,
                      vt[i].exp_match, vt[i].exp_acks);

        run_read("rd_0002", 16'h0002, 2);

        // STOP after the 4th bit of the low data byte
        we0 = we_addr_q.size();
        m_start();
        m_write_byte(8'h14, ack);
        m_write_byte(8'h00, ack);
        m_write_byte(8'h40, ack);
        m_write_byte(8'h12, ack);
        for (int i = 0; i < 4; i++) m_send_bit(i[0]);
        m_stop();
        tick(4);
        model_ptr = 16'h0040;
        chk("midstop no_we", we_addr_q.size() - we0, 0);
        chk("midstop state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("midstop busy", 32'(busy), 0);
        chk("midstop reg_addr", reg_addr, model_ptr);

        // Reset while the target is driving a 0 during the high read byte
        m_start();
        m_write_byte(8'h14, ack);
        m_write_byte(8'h00, ack);
        m_write_byte(8'h02, ack);
        m_start();
        m_write_byte(8'h15, ack);
        m_recv_bit(ack);
        waited = 0;
        @(negedge clk);
        while (!sda_oe && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("rdrst oe_driven", 32'(sda_oe), 1);
        we0 = we_addr_q.size();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rdrst oe_released", 32'(sda_oe), 0);
        @(negedge clk);
        rst = 1'b0;
        m_scl = 1'b1; m_sda = 1'b1;
        tick(3 * H);
        model_ptr = 16'h0000;
        chk("rdrst no_we", we_addr_q.size() - we0, 0);
        chk("rdrst busy", 32'(busy), 0);
        run_write("after_rst", 7'h0A, 16'h0030, 1, {16'h0, 16'h0, 16'h0, 16'h1234}, 1'b1, 5);

        // Randomized writes and reads against the pointer/memory model
        for (int k = 0; k < 5; k++) begin
            rdev = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0A;
            rptr = 16'($urandom) & 16'hFFFE;
            rnw  = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) rdat[j] = 16'($urandom);
            run_write($sformatf("rw%0d", k), rdev, rptr, rnw, rdat,
                      rdev == 7'h0A, (rdev == 7'h0A) ? 3 + 2 * rnw : 0);
        end
        for (int k = 0; k < 3; k++) begin
            rptr = 16'($urandom) & 16'hFFFE;
            run_read($sformatf("rr%0d", k), rptr, $urandom_range(1, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
